// File: rtl/fractal_sync_port_arb_if.sv
// Fractal-sync arbiter bundle: local requester side plus the shared upstream port.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface fractal_sync_port_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LVL_W = 2,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ*LVL_W-1:0] req_level_i;
    logic [N_REQ*ID_W-1:0]  req_id_i;
    logic [N_REQ-1:0]       rsp_valid_o;
    logic                   up_req_valid_o;
    logic                   up_req_ready_i;
    logic [LVL_W-1:0]       up_req_level_o;
    logic [ID_W-1:0]        up_req_id_o;
    logic                   up_rsp_valid_i;
    logic [LVL_W-1:0]       up_rsp_level_i;
    logic [ID_W-1:0]        up_rsp_id_i;
    logic                   unmatched_o;

    modport slave (
        input  req_valid_i, req_level_i, req_id_i,
        input  up_req_ready_i, up_rsp_valid_i, up_rsp_level_i, up_rsp_id_i,
        output req_ready_o, rsp_valid_o,
        output up_req_valid_o, up_req_level_o, up_req_id_o, unmatched_o
    );

    modport master (
        output req_valid_i, req_level_i, req_id_i,
        output up_req_ready_i, up_rsp_valid_i, up_rsp_level_i, up_rsp_id_i,
        input  req_ready_o, rsp_valid_o,
        input  up_req_valid_o, up_req_level_o, up_req_id_o, unmatched_o
    );
endinterface

// File: rtl/fractal_sync_port_arb.sv
// Shares one upstream fractal-sync port among N_REQ local requesters: round-robin
// forwarding with many barriers outstanding, responses broadcast to all matching waiters.
module fractal_sync_port_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LVL_W = 2,
    parameter int unsigned ID_W  = 2
) (
    input logic                    clk_i,
    input logic                    rst_i,
    fractal_sync_port_arb_if.slave bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SENT = 2'd2
    } entry_state_e;

    entry_state_e     state_q [N_REQ];
    entry_state_e     state_d [N_REQ];
    logic [LVL_W-1:0] level_q [N_REQ];
    logic [ID_W-1:0]  id_q    [N_REQ];

    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [LVL_W-1:0] out_level_q;
    logic [ID_W-1:0]  out_id_q;
    logic [IDX_W-1:0] rr_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic             unmatched_q;

    logic             handshake;
    logic             load;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [N_REQ-1:0] match;
    logic [N_REQ-1:0] accept;
    logic [N_REQ-1:0] ready;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    assign handshake = out_valid_q & bus.up_req_ready_i;
    assign load      = ~out_valid_q | handshake;

    // The entry sitting in the output register is still PEND, so it must be skipped here.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = wrap_add(rr_q, off);
            if (!grant_found && state_q[cand] == PEND && !(out_valid_q && cand == out_idx_q)) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        match  = '0;
        accept = '0;
        ready  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            ready[k]  = (state_q[k] == IDLE);
            accept[k] = bus.req_valid_i[k] && (state_q[k] == IDLE);
            match[k]  = bus.up_rsp_valid_i && (state_q[k] == SENT)
                     && (level_q[k] == bus.up_rsp_level_i)
                     && (id_q[k] == bus.up_rsp_id_i);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                IDLE:    if (accept[k]) state_d[k] = PEND;
                PEND:    if (handshake && out_idx_q == IDX_W'(k)) state_d[k] = SENT;
                SENT:    if (match[k]) state_d[k] = IDLE;
                default: state_d[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                state_q[k] <= IDLE;
                level_q[k] <= '0;
                id_q[k]    <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                state_q[k] <= state_d[k];
                if (accept[k]) begin
                    level_q[k] <= bus.req_level_i[k*LVL_W +: LVL_W];
                    id_q[k]    <= bus.req_id_i[k*ID_W +: ID_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_level_q <= '0;
            out_id_q    <= '0;
            rr_q        <= '0;
            rsp_valid_q <= '0;
            unmatched_q <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q <= grant_found;
                if (grant_found) begin
                    out_idx_q   <= grant_idx;
                    out_level_q <= level_q[grant_idx];
                    out_id_q    <= id_q[grant_idx];
                    rr_q        <= wrap_add(grant_idx, 1);
                end
            end
            rsp_valid_q <= match;
            unmatched_q <= bus.up_rsp_valid_i & ~(|match);
        end
    end

    assign bus.req_ready_o    = ready;
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.up_req_valid_o = out_valid_q;
    assign bus.up_req_level_o = out_level_q;
    assign bus.up_req_id_o    = out_id_q;
    assign bus.unmatched_o    = unmatched_q;
endmodule

// File: tb/tb_fractal_sync_port_arb.sv
// Bench for fractal_sync_port_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of waiting/sent barriers and the round-robin grant.
module tb_fractal_sync_port_arb;
    localparam int N  = 4;
    localparam int LW = 2;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fractal_sync_port_arb_if #(.N_REQ(N), .LVL_W(LW), .ID_W(IW)) bus ();

    fractal_sync_port_arb #(.N_REQ(N), .LVL_W(LW), .ID_W(IW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: which requesters wait to be forwarded, which are forwarded, and the upstream slot.
    bit         m_wait [N];
    bit         m_sent [N];
    int         m_lvl  [N];
    int         m_id   [N];
    bit         m_ov;
    int         m_who;
    int         m_olvl;
    int         m_oid;
    int         m_ptr;
    bit [N-1:0] m_rsp;
    bit         m_unm;

    function automatic bit [N-1:0] exp_ready();
        bit [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = !(m_wait[k] || m_sent[k]);
        return r;
    endfunction

    task automatic tick();
        bit [N-1:0] rel;
        bit [N-1:0] acc;
        bit hs;
        bit found;
        int g;
        int c;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_wait[k] = 0;
                m_sent[k] = 0;
            end
            m_ov = 0; m_ptr = 0; m_rsp = '0; m_unm = 0;
        end else begin
            rel = '0;
            acc = '0;
            for (int k = 0; k < N; k++) begin
                if (bus.up_rsp_valid_i && m_sent[k] && m_lvl[k] == int'(bus.up_rsp_level_i)
                    && m_id[k] == int'(bus.up_rsp_id_i)) rel[k] = 1;
                if (bus.req_valid_i[k] && !m_wait[k] && !m_sent[k]) acc[k] = 1;
            end
            hs = m_ov && bus.up_req_ready_i;
            found = 0;
            g = 0;
            if (!m_ov || hs) begin
                for (int off = 0; off < N; off++) begin
                    c = (m_ptr + off) % N;
                    if (!found && m_wait[c] && !(m_ov && c == m_who)) begin
                        found = 1;
                        g = c;
                    end
                end
            end
            if (hs) begin
                m_wait[m_who] = 0;
                m_sent[m_who] = 1;
            end
            for (int k = 0; k < N; k++) begin
                if (rel[k]) m_sent[k] = 0;
                if (acc[k]) begin
                    m_wait[k] = 1;
                    m_lvl[k]  = int'(bus.req_level_i[k*LW +: LW]);
                    m_id[k]   = int'(bus.req_id_i[k*IW +: IW]);
                end
            end
            if (!m_ov || hs) begin
                m_ov = found;
                if (found) begin
                    m_who  = g;
                    m_olvl = m_lvl[g];
                    m_oid  = m_id[g];
                    m_ptr  = (g + 1) % N;
                end
            end
            m_rsp = rel;
            m_unm = bus.up_rsp_valid_i && (rel == '0);
        end
        @(negedge clk);
    endtask

    task automatic drive_req(input int k, input bit v, input int lvl, input int id);
        bus.req_valid_i[k]           = v;
        bus.req_level_i[k*LW +: LW] = LW'(lvl);
        bus.req_id_i[k*IW +: IW]    = IW'(id);
    endtask

    task automatic drive_rsp(input bit v, input int lvl, input int id);
        bus.up_rsp_valid_i = v;
        bus.up_rsp_level_i = LW'(lvl);
        bus.up_rsp_id_i    = IW'(id);
    endtask

    task automatic idle_inputs();
        bus.req_valid_i    = '0;
        bus.req_level_i    = '0;
        bus.req_id_i       = '0;
        bus.up_req_ready_i = 1'b1;
        drive_rsp(0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.req_ready_o !== 4'b1111) begin
            n_errors++; $display("FAIL reset_ready: got %b expected 1111", bus.req_ready_o);
        end
        n_checks++;
        if (bus.up_req_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_up_valid: got %b expected 0", bus.up_req_valid_o);
        end
        n_checks++;
        if (bus.rsp_valid_o !== 4'b0000) begin
            n_errors++; $display("FAIL reset_rsp: got %b expected 0000", bus.rsp_valid_o);
        end
        n_checks++;
        if (bus.unmatched_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_unmatched: got %b expected 0", bus.unmatched_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive_req(0, 1, 1, 2);
        tick();
        drive_req(0, 0, 0, 0);
        n_checks++;
        if (bus.up_req_valid_o !== 1'b0 || bus.req_ready_o !== 4'b1110) begin
            n_errors++;
            $display("FAIL single_gap: got valid=%b ready=%b expected valid=0 ready=1110",
                     bus.up_req_valid_o, bus.req_ready_o);
        end
        tick();
        n_checks++;
        if ({bus.up_req_valid_o, bus.up_req_level_o, bus.up_req_id_o} !== 5'b1_01_10) begin
            n_errors++;
            $display("FAIL single_up: got v=%b l=%0d i=%0d expected v=1 l=1 i=2",
                     bus.up_req_valid_o, bus.up_req_level_o, bus.up_req_id_o);
        end
        tick();
        n_checks++;
        if (bus.up_req_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL single_drain: got %b expected 0", bus.up_req_valid_o);
        end
        tick();
        tick();
        drive_rsp(1, 1, 2);
        tick();
        drive_rsp(0, 0, 0);
        n_checks++;
        if (bus.rsp_valid_o !== 4'b0001 || bus.req_ready_o !== 4'b1111) begin
            n_errors++;
            $display("FAIL single_release: got rsp=%b ready=%b expected rsp=0001 ready=1111",
                     bus.rsp_valid_o, bus.req_ready_o);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid_o !== 4'b0000) begin
            n_errors++; $display("FAIL single_pulse_width: got %b expected 0000", bus.rsp_valid_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < N; k++) drive_req(k, 1, 0, (round == 0) ? k : N - 1 - k);
            tick();
            for (int k = 0; k < N; k++) drive_req(k, 0, 0, 0);
            tick();
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (bus.up_req_valid_o !== 1'b1
                    || int'(bus.up_req_id_o) != ((round == 0) ? i : N - 1 - i)) begin
                    n_errors++;
                    $display("FAIL rr_order r%0d s%0d: got v=%b id=%0d expected v=1 id=%0d",
                             round, i, bus.up_req_valid_o, bus.up_req_id_o,
                             (round == 0) ? i : N - 1 - i);
                end
                tick();
            end
            for (int k = 0; k < N; k++) begin
                drive_rsp(1, 0, (round == 0) ? k : N - 1 - k);
                tick();
                n_checks++;
                if (bus.rsp_valid_o !== 4'(1 << k)) begin
                    n_errors++;
                    $display("FAIL rr_release r%0d k%0d: got %b expected %b",
                             round, k, bus.rsp_valid_o, 4'(1 << k));
                end
            end
            drive_rsp(0, 0, 0);
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.up_req_ready_i = 1'b0;
        drive_req(1, 1, 3, 1);
        drive_req(2, 1, 2, 3);
        tick();
        drive_req(1, 0, 0, 0);
        drive_req(2, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.up_req_valid_o, bus.up_req_level_o, bus.up_req_id_o} !== 5'b1_11_01
                || bus.req_ready_o !== 4'b1001) begin
                n_errors++;
                $display("FAIL bp_hold c%0d: got v=%b l=%0d i=%0d ready=%b expected v=1 l=3 i=1 ready=1001",
                         i, bus.up_req_valid_o, bus.up_req_level_o, bus.up_req_id_o, bus.req_ready_o);
            end
            tick();
        end
        bus.up_req_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({bus.up_req_valid_o, bus.up_req_level_o, bus.up_req_id_o} !== 5'b1_10_11) begin
            n_errors++;
            $display("FAIL bp_next: got v=%b l=%0d i=%0d expected v=1 l=2 i=3",
                     bus.up_req_valid_o, bus.up_req_level_o, bus.up_req_id_o);
        end
        tick();
    endtask

    task automatic test_shared();
        do_reset();
        drive_req(1, 1, 2, 1);
        drive_req(3, 1, 2, 1);
        tick();
        drive_req(1, 0, 0, 0);
        drive_req(3, 0, 0, 0);
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.up_req_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0101) begin
            n_errors++;
            $display("FAIL shared_sent: got v=%b ready=%b expected v=0 ready=0101",
                     bus.up_req_valid_o, bus.req_ready_o);
        end
        drive_rsp(1, 2, 1);
        tick();
        drive_rsp(1, 0, 3);
        n_checks++;
        if (bus.rsp_valid_o !== 4'b1010 || bus.unmatched_o !== 1'b0) begin
            n_errors++;
            $display("FAIL shared_release: got rsp=%b unm=%b expected rsp=1010 unm=0",
                     bus.rsp_valid_o, bus.unmatched_o);
        end
        tick();
        drive_rsp(0, 0, 0);
        n_checks++;
        if (bus.rsp_valid_o !== 4'b0000 || bus.unmatched_o !== 1'b1) begin
            n_errors++;
            $display("FAIL shared_unmatched: got rsp=%b unm=%b expected rsp=0000 unm=1",
                     bus.rsp_valid_o, bus.unmatched_o);
        end
        tick();
        n_checks++;
        if (bus.unmatched_o !== 1'b0) begin
            n_errors++; $display("FAIL unmatched_width: got %b expected 0", bus.unmatched_o);
        end
    endtask

    task automatic test_race();
        do_reset();
        bus.up_req_ready_i = 1'b0;
        drive_req(2, 1, 1, 0);
        tick();
        drive_req(2, 0, 0, 0);
        tick();
        bus.up_req_ready_i = 1'b1;
        drive_rsp(1, 1, 0);
        tick();
        drive_rsp(0, 0, 0);
        n_checks++;
        if (bus.rsp_valid_o !== 4'b0000 || bus.req_ready_o !== 4'b1011
            || bus.up_req_valid_o !== 1'b0 || bus.unmatched_o !== 1'b1) begin
            n_errors++;
            $display("FAIL race_hold: got rsp=%b ready=%b v=%b unm=%b expected rsp=0000 ready=1011 v=0 unm=1",
                     bus.rsp_valid_o, bus.req_ready_o, bus.up_req_valid_o, bus.unmatched_o);
        end
        tick();
        drive_rsp(1, 1, 0);
        tick();
        drive_rsp(0, 0, 0);
        n_checks++;
        if (bus.rsp_valid_o !== 4'b0100 || bus.unmatched_o !== 1'b0 || bus.req_ready_o !== 4'b1111) begin
            n_errors++;
            $display("FAIL race_release: got rsp=%b unm=%b ready=%b expected rsp=0100 unm=0 ready=1111",
                     bus.rsp_valid_o, bus.unmatched_o, bus.req_ready_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_req(0, 1, 1, 1);
        drive_req(1, 1, 2, 2);
        drive_req(2, 1, 3, 3);
        tick();
        for (int k = 0; k < 3; k++) drive_req(k, 0, 0, 0);
        tick();
        tick();
        tick();
        bus.up_req_ready_i = 1'b0;
        n_checks++;
        if (bus.req_ready_o !== 4'b1000 || bus.up_req_valid_o !== 1'b1 || int'(bus.up_req_id_o) != 3) begin
            n_errors++;
            $display("FAIL mid_setup: got ready=%b v=%b id=%0d expected ready=1000 v=1 id=3",
                     bus.req_ready_o, bus.up_req_valid_o, bus.up_req_id_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.req_ready_o !== 4'b1111 || bus.up_req_valid_o !== 1'b0
            || bus.rsp_valid_o !== 4'b0000 || bus.unmatched_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: got ready=%b v=%b rsp=%b unm=%b expected 1111 0 0000 0",
                     bus.req_ready_o, bus.up_req_valid_o, bus.rsp_valid_o, bus.unmatched_o);
        end
        drive_rsp(1, 1, 1);
        tick();
        drive_rsp(0, 0, 0);
        n_checks++;
        if (bus.unmatched_o !== 1'b1 || bus.rsp_valid_o !== 4'b0000) begin
            n_errors++;
            $display("FAIL mid_stale_rsp: got unm=%b rsp=%b expected unm=1 rsp=0000",
                     bus.unmatched_o, bus.rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            n_checks++;
            if (bus.req_ready_o !== exp_ready() || bus.up_req_valid_o !== m_ov
                || bus.rsp_valid_o !== m_rsp || bus.unmatched_o !== m_unm) begin
                n_errors++;
                $display("FAIL rand_ctrl c%0d: got ready=%b v=%b rsp=%b unm=%b expected ready=%b v=%b rsp=%b unm=%b",
                         cyc, bus.req_ready_o, bus.up_req_valid_o, bus.rsp_valid_o, bus.unmatched_o,
                         exp_ready(), m_ov, m_rsp, m_unm);
            end
            if (m_ov) begin
                n_checks++;
                if (int'(bus.up_req_level_o) != m_olvl || int'(bus.up_req_id_o) != m_oid) begin
                    n_errors++;
                    $display("FAIL rand_data c%0d: got l=%0d i=%0d expected l=%0d i=%0d",
                             cyc, bus.up_req_level_o, bus.up_req_id_o, m_olvl, m_oid);
                end
            end
            for (int r = 0; r < N; r++)
                drive_req(r, ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
            bus.up_req_ready_i = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, N - 1);
                if (m_sent[k] && $urandom_range(0, 3) != 0) drive_rsp(1, m_lvl[k], m_id[k]);
                else drive_rsp(1, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                drive_rsp(0, 0, 0);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_shared();
        test_race();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
